// File: rtl/lane_controller_if.sv
// rtl/lane_controller_if.sv - button, frame-tick and offset signals of the lane controller
interface lane_controller_if #(
   parameter int HWIDTH = 12
);
   logic                     BTNL;
   logic                     BTNR;
   logic                     frame_tick;
   logic                     en;
   logic signed [HWIDTH-1:0] hoffset;
   logic [1:0]               lane;
   logic                     moving;

   modport master (
      output BTNL, BTNR, frame_tick, en,
      input  hoffset, lane, moving
   );

   modport slave (
      input  BTNL, BTNR, frame_tick, en,
      output hoffset, lane, moving
   );
endinterface

// File: rtl/lane_controller.sv
// rtl/lane_controller.sv - debounced left/right lane selection with per-frame offset stepping
module lane_controller #(
   parameter int HWIDTH          = 12,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LANE_DX         = 100,
   parameter int STEP            = 20
) (
   input  logic              CLK100MHZ,
   input  logic              CPU_RESETN,
   lane_controller_if.slave  bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic signed [HWIDTH-1:0] LDX    = HWIDTH'(LANE_DX);
   localparam logic signed [HWIDTH-1:0] STEP_H = HWIDTH'(STEP);
   localparam logic signed [HWIDTH:0]   STEP_W = (HWIDTH + 1)'(STEP);

   typedef enum logic {IDLE, MOVE} state_t;

   // Bit 0 carries the left button, bit 1 the right button.
   logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]          deb_q, deb_d, press_q, press_d;
   logic [1:0][CW-1:0]  cnt_q, cnt_d;
   state_t              state_q, state_d;
   logic [1:0]          lane_q, lane_d;
   logic signed [HWIDTH-1:0] hoff_q, hoff_d, target;
   logic signed [HWIDTH:0]   diff;
   logic                pend_vld_q, pend_vld_d, pend_right_q, pend_right_d;
   logic                ev_l, ev_r, near;

   always_comb begin
      sync1_d = {bus.BTNR, bus.BTNL};
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
      press_d = deb_d & ~deb_q;
   end

   always_comb begin
      ev_l = press_q[0] & ~press_q[1] & bus.en;
      ev_r = press_q[1] & ~press_q[0] & bus.en;
      case (lane_q)
         2'd0:    target = -LDX;
         2'd2:    target = LDX;
         default: target = '0;
      endcase
      diff = (HWIDTH + 1)'(target) - (HWIDTH + 1)'(hoff_q);
      near = (diff <= STEP_W) && (diff >= -STEP_W);

      state_d      = state_q;
      lane_d       = lane_q;
      hoff_d       = hoff_q;
      pend_vld_d   = pend_vld_q;
      pend_right_d = pend_right_q;

      case (state_q)
         IDLE: begin
            pend_vld_d = 1'b0;
            if (ev_l && lane_q != 2'd0) begin
               lane_d  = lane_q - 2'd1;
               state_d = MOVE;
            end else if (ev_r && lane_q != 2'd2) begin
               lane_d  = lane_q + 2'd1;
               state_d = MOVE;
            end
         end
         default: begin
            if (ev_l || ev_r) begin
               pend_vld_d   = 1'b1;
               pend_right_d = ev_r;
            end
            if (!bus.en) pend_vld_d = 1'b0;
            if (bus.frame_tick) begin
               if (near) begin
                  hoff_d  = target;
                  state_d = IDLE;
                  // A queued press chains straight into the next move without an idle cycle.
                  if (pend_vld_d) begin
                     pend_vld_d = 1'b0;
                     if (pend_right_d && lane_q != 2'd2) begin
                        lane_d  = lane_q + 2'd1;
                        state_d = MOVE;
                     end else if (!pend_right_d && lane_q != 2'd0) begin
                        lane_d  = lane_q - 2'd1;
                        state_d = MOVE;
                     end
                  end
               end else if (diff < 0) begin
                  hoff_d = hoff_q - STEP_H;
               end else begin
                  hoff_d = hoff_q + STEP_H;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         press_q      <= '0;
         cnt_q        <= '0;
         state_q      <= IDLE;
         lane_q       <= 2'd1;
         hoff_q       <= '0;
         pend_vld_q   <= 1'b0;
         pend_right_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         deb_q        <= deb_d;
         press_q      <= press_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         lane_q       <= lane_d;
         hoff_q       <= hoff_d;
         pend_vld_q   <= pend_vld_d;
         pend_right_q <= pend_right_d;
      end
   end

   assign bus.hoffset = hoff_q;
   assign bus.lane    = lane_q;
   assign bus.moving  = (state_q == MOVE);
endmodule
